// File: rtl/video_mem_pkg.sv
// video_mem_pkg: shared constants, enums and address-decode helpers for the
// video memory responder.
//   VRAM window  : $8000-$9FFF (8 KiB)
//   OAM window   : $FE00-$FE9F (160 bytes)
//   OPEN_BUS     : value returned for any access that misses or is locked out
package video_mem_pkg;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_LAST = 16'h9FFF;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] OAM_LAST  = 16'hFE9F;
  localparam logic [7:0]  OPEN_BUS  = 8'hFF;

  // Read channels handled by the responder
  localparam int NUM_CH = 3;
  localparam int CH_PPU = 0;
  localparam int CH_OAM = 1;
  localparam int CH_CPU = 2;

  typedef enum logic [1:0] {HBLANK, VBLANK, OAM_SCAN, DRAWING} ppu_mode_t;

  typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} resp_state_t;

  // $8000-$9FFF, i.e. addr[15:13] == 3'b100
  function automatic logic vram_hit(input logic [15:0] addr);
    return (addr >= VRAM_BASE) && (addr <= VRAM_LAST);
  endfunction

  function automatic logic oam_hit(input logic [15:0] addr);
    return (addr >= OAM_BASE) && (addr <= OAM_LAST);
  endfunction

endpackage

// File: rtl/video_mem_responder_if.sv
// video_mem_if: request/response bundle between the PPU + CPU side (master)
// and the video memory responder (slave).
//   ppu_*    : PPU tile/map fetch, level request held until data_valid_out
//   oam_*    : PPU OAM scan read, level request held until oam_data_valid_out
//   mode_in  : current PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 drawing)
//   cpu_*    : CPU port, one-cycle cpu_req_in strobe, cpu_we_in selects write
interface video_mem_if;

  logic [15:0] ppu_addr_in;
  logic        ppu_addr_valid_in;
  logic [7:0]  data_out;
  logic        data_valid_out;

  logic [15:0] oam_addr_in;
  logic        oam_addr_valid_in;
  logic [7:0]  oam_data_out;
  logic        oam_data_valid_out;

  logic [1:0]  mode_in;

  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_wdata_in;
  logic        cpu_req_in;
  logic        cpu_we_in;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_rvalid_out;

  modport master (
    output ppu_addr_in, ppu_addr_valid_in, oam_addr_in, oam_addr_valid_in,
    output mode_in, cpu_addr_in, cpu_wdata_in, cpu_req_in, cpu_we_in,
    input  data_out, data_valid_out, oam_data_out, oam_data_valid_out,
    input  cpu_rdata_out, cpu_rvalid_out
  );

  modport slave (
    input  ppu_addr_in, ppu_addr_valid_in, oam_addr_in, oam_addr_valid_in,
    input  mode_in, cpu_addr_in, cpu_wdata_in, cpu_req_in, cpu_we_in,
    output data_out, data_valid_out, oam_data_out, oam_data_valid_out,
    output cpu_rdata_out, cpu_rvalid_out
  );

endinterface

// File: rtl/video_mem_responder_dpram.sv
// video_dpram: true dual-port RAM, read-first, two-cycle registered read.
//   clk, rst_n           : clock, async active-low reset (pipeline only,
//                          array contents are never cleared)
//   a_addr/a_we/a_wdata  : port A address / write enable / write data
//   a_rdata              : port A read data, two edges after the address
//   b_*                  : port B, same as port A
module video_dpram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    a_addr,
  input  logic             a_we,
  input  logic [WIDTH-1:0] a_wdata,
  output logic [WIDTH-1:0] a_rdata,
  input  logic [AW-1:0]    b_addr,
  input  logic             b_we,
  input  logic [WIDTH-1:0] b_wdata,
  output logic [WIDTH-1:0] b_rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] a_q1_r, a_q2_r, b_q1_r, b_q2_r;

  // Array writes; port B wins if both ports write the same word
  always_ff @(posedge clk) begin
    if (a_we) mem_r[a_addr] <= a_wdata;
    if (b_we) mem_r[b_addr] <= b_wdata;
  end

  // Read pipeline: the array is sampled before this edge's write lands (read-first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q1_r <= {WIDTH{1'b0}};
      a_q2_r <= {WIDTH{1'b0}};
      b_q1_r <= {WIDTH{1'b0}};
      b_q2_r <= {WIDTH{1'b0}};
    end else begin
      a_q1_r <= mem_r[a_addr];
      a_q2_r <= a_q1_r;
      b_q1_r <= mem_r[b_addr];
      b_q2_r <= b_q1_r;
    end
  end

  assign a_rdata = a_q2_r;
  assign b_rdata = b_q2_r;

endmodule

// File: rtl/video_mem_responder.sv
// video_mem_responder: owns VRAM ($8000-$9FFF) and OAM ($FE00-$FE9F).
// Three independent read channels (PPU-VRAM, PPU-OAM, CPU), each walking
// IDLE -> RD1 -> RD2 -> RESP. Accept at edge N, data registered at N+2,
// valid pulse in the cycle ending at N+3. Misses return $FF with the same
// timing. CPU writes complete in one cycle on the RAMs' port B.
//   clk_in    : 100 MHz system clock
//   rst_n_in  : asynchronous active-low reset
//   bus       : video_mem_if.slave (PPU fetch, OAM scan, mode, CPU port)
// Build option: define VIDEO_MEM_LOCK_EN to gate CPU access by PPU mode
// (mode 3 locks VRAM and OAM, mode 2 locks OAM), sampled when the request
// is taken. Without it the CPU always has access and mode_in is ignored.
module video_mem_responder
  import video_mem_pkg::*;
#(
  parameter int VRAM_DEPTH = 8192,
  parameter int OAM_DEPTH  = 160
) (
  input logic        clk_in,
  input logic        rst_n_in,
  video_mem_if.slave bus
);

  localparam int VRAM_AW = $clog2(VRAM_DEPTH);
  localparam int OAM_AW  = $clog2(OAM_DEPTH);

  logic vram_open_s;
  logic oam_open_s;

`ifdef VIDEO_MEM_LOCK_EN
  // CPU access windows for the current PPU mode
  always_comb begin
    vram_open_s = 1'b1;
    oam_open_s  = 1'b1;
    case (ppu_mode_t'(bus.mode_in))
      DRAWING: begin
        vram_open_s = 1'b0;
        oam_open_s  = 1'b0;
      end
      OAM_SCAN: begin
        vram_open_s = 1'b1;
        oam_open_s  = 1'b0;
      end
      default: begin
        vram_open_s = 1'b1;
        oam_open_s  = 1'b1;
      end
    endcase
  end
`else
  logic unused_mode_s;
  assign unused_mode_s = ^bus.mode_in;
  assign vram_open_s   = 1'b1;
  assign oam_open_s    = 1'b1;
`endif

  logic [NUM_CH-1:0] req_s;
  logic              cpu_wr_s;

  assign req_s[CH_PPU] = bus.ppu_addr_valid_in;
  assign req_s[CH_OAM] = bus.oam_addr_valid_in;
  assign req_s[CH_CPU] = bus.cpu_req_in & ~bus.cpu_we_in;
  assign cpu_wr_s      = bus.cpu_req_in & bus.cpu_we_in;

  resp_state_t       state_r     [NUM_CH];
  resp_state_t       state_nxt_s [NUM_CH];
  logic [15:0]       addr_r      [NUM_CH];
  logic [15:0]       cur_addr_s  [NUM_CH];
  logic [NUM_CH-1:0] hit_r;
  logic [NUM_CH-1:0] hit_now_s;
  logic [NUM_CH-1:0] accept_s;
  logic [NUM_CH-1:0] load_s;

  // Live request address while idle so the RAM samples it on the accept
  // edge; afterwards the latched copy keeps the RAM address stable
  always_comb begin
    cur_addr_s[CH_PPU] = (state_r[CH_PPU] == IDLE) ? bus.ppu_addr_in : addr_r[CH_PPU];
    cur_addr_s[CH_OAM] = (state_r[CH_OAM] == IDLE) ? bus.oam_addr_in : addr_r[CH_OAM];
    cur_addr_s[CH_CPU] = (state_r[CH_CPU] == IDLE) ? bus.cpu_addr_in : addr_r[CH_CPU];
  end

  // Range decode; the CPU hit already folds in the mode lock
  always_comb begin
    hit_now_s         = {NUM_CH{1'b0}};
    hit_now_s[CH_PPU] = vram_hit(cur_addr_s[CH_PPU]);
    hit_now_s[CH_OAM] = oam_hit(cur_addr_s[CH_OAM]);
    hit_now_s[CH_CPU] = (vram_hit(cur_addr_s[CH_CPU]) & vram_open_s) |
                        (oam_hit(cur_addr_s[CH_CPU])  & oam_open_s);
  end

  // Channel FSM next state
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_nxt_s[ch] = state_r[ch];
      case (state_r[ch])
        IDLE: begin
          if (req_s[ch]) state_nxt_s[ch] = RD1;
          else           state_nxt_s[ch] = IDLE;
        end
        RD1:     state_nxt_s[ch] = RD2;
        RD2:     state_nxt_s[ch] = RESP;
        RESP:    state_nxt_s[ch] = IDLE;
        default: state_nxt_s[ch] = IDLE;
      endcase
    end
  end

  // Channel FSM output decode: accept strobe and response load strobe
  always_comb begin
    accept_s = {NUM_CH{1'b0}};
    load_s   = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      accept_s[ch] = (state_r[ch] == IDLE) & req_s[ch];
      load_s[ch]   = (state_r[ch] == RD2);
    end
  end

  // Channel FSM state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int ch = 0; ch < NUM_CH; ch++) state_r[ch] <= IDLE;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) state_r[ch] <= state_nxt_s[ch];
    end
  end

  // Request address and hit flag, captured on accept
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_r <= {NUM_CH{1'b0}};
      for (int ch = 0; ch < NUM_CH; ch++) addr_r[ch] <= 16'h0000;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (accept_s[ch]) begin
          addr_r[ch] <= cur_addr_s[ch];
          hit_r[ch]  <= hit_now_s[ch];
        end
      end
    end
  end

  // Port B address: a CPU write takes the port for its single cycle; an
  // in-flight CPU read has already sampled the array by then
  logic [VRAM_AW-1:0] vram_b_addr_s;
  logic [OAM_AW-1:0]  oam_b_addr_s;
  logic               vram_we_s;
  logic               oam_we_s;
  logic [7:0]         vram_qa_s, vram_qb_s, oam_qa_s, oam_qb_s;
  logic [7:0]         cpu_rd_s;

  assign vram_b_addr_s = cpu_wr_s ? bus.cpu_addr_in[VRAM_AW-1:0] : cur_addr_s[CH_CPU][VRAM_AW-1:0];
  assign oam_b_addr_s  = cpu_wr_s ? bus.cpu_addr_in[OAM_AW-1:0]  : cur_addr_s[CH_CPU][OAM_AW-1:0];
  assign vram_we_s     = cpu_wr_s & vram_hit(bus.cpu_addr_in) & vram_open_s;
  assign oam_we_s      = cpu_wr_s & oam_hit(bus.cpu_addr_in)  & oam_open_s;

  // CPU read data comes from whichever RAM the latched address targets
  assign cpu_rd_s = oam_hit(cur_addr_s[CH_CPU]) ? oam_qb_s : vram_qb_s;

  video_dpram #(.DEPTH(VRAM_DEPTH), .WIDTH(8)) u_vram (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .a_addr  (cur_addr_s[CH_PPU][VRAM_AW-1:0]),
    .a_we    (1'b0),
    .a_wdata (8'h00),
    .a_rdata (vram_qa_s),
    .b_addr  (vram_b_addr_s),
    .b_we    (vram_we_s),
    .b_wdata (bus.cpu_wdata_in),
    .b_rdata (vram_qb_s)
  );

  video_dpram #(.DEPTH(OAM_DEPTH), .WIDTH(8)) u_oam (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .a_addr  (cur_addr_s[CH_OAM][OAM_AW-1:0]),
    .a_we    (1'b0),
    .a_wdata (8'h00),
    .a_rdata (oam_qa_s),
    .b_addr  (oam_b_addr_s),
    .b_we    (oam_we_s),
    .b_wdata (bus.cpu_wdata_in),
    .b_rdata (oam_qb_s)
  );

  logic [NUM_CH-1:0] valid_r;
  logic [7:0]        ppu_data_r, oam_data_r, cpu_rdata_r;

  // Response registers: data holds until the next response, valid pulses in RESP
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_r     <= {NUM_CH{1'b0}};
      ppu_data_r  <= 8'h00;
      oam_data_r  <= 8'h00;
      cpu_rdata_r <= 8'h00;
    end else begin
      valid_r <= load_s;
      if (load_s[CH_PPU]) ppu_data_r  <= hit_r[CH_PPU] ? vram_qa_s : OPEN_BUS;
      if (load_s[CH_OAM]) oam_data_r  <= hit_r[CH_OAM] ? oam_qa_s  : OPEN_BUS;
      if (load_s[CH_CPU]) cpu_rdata_r <= hit_r[CH_CPU] ? cpu_rd_s  : OPEN_BUS;
    end
  end

  assign bus.data_out           = ppu_data_r;
  assign bus.data_valid_out     = valid_r[CH_PPU];
  assign bus.oam_data_out       = oam_data_r;
  assign bus.oam_data_valid_out = valid_r[CH_OAM];
  assign bus.cpu_rdata_out      = cpu_rdata_r;
  assign bus.cpu_rvalid_out     = valid_r[CH_CPU];

endmodule

// File: tb/tb_video_mem_responder.sv
// tb_video_mem_responder: scoreboard bench for video_mem_responder.
// Each read pushes {expected byte, expected pulse cycle} onto its channel's
// queue; a negedge monitor pops and compares on every valid pulse, and flags
// pulses that are missing, early, late or unexpected.
module tb_video_mem_responder;

`ifdef VIDEO_MEM_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_mem_if vif();

  video_mem_responder dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (vif.slave)
  );

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } exp_t;

  exp_t        sb_q [3][$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  string       ch_name [3] = '{"ppu", "oam", "cpu"};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] mon_v;
  logic [7:0] mon_d [3];
  exp_t       mon_e;

  // Response monitor, sampled on the falling edge
  always @(negedge clk) begin
    mon_v    = {vif.cpu_rvalid_out, vif.oam_data_valid_out, vif.data_valid_out};
    mon_d[0] = vif.data_out;
    mon_d[1] = vif.oam_data_out;
    mon_d[2] = vif.cpu_rdata_out;
    for (int ch = 0; ch < 3; ch++) begin
      if (mon_v[ch]) begin
        if (sb_q[ch].size() == 0) begin
          check_val({ch_name[ch], "_spurious"}, 32'(sb_q[ch].size()), 32'd1);
        end else begin
          mon_e = sb_q[ch].pop_front();
          check_val({ch_name[ch], "_data"}, {24'd0, mon_d[ch]}, {24'd0, mon_e.data});
          check_val({ch_name[ch], "_cycle"}, cyc, mon_e.due);
        end
      end else if (sb_q[ch].size() != 0 && sb_q[ch][0].due <= cyc) begin
        check_val({ch_name[ch], "_pulse"}, {31'd0, mon_v[ch]}, 32'd1);
        void'(sb_q[ch].pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept happens at the next edge N; pulse is seen at the negedge after N+2
  task automatic ppu_start(input logic [15:0] a, input logic [7:0] e);
    vif.ppu_addr_in       = a;
    vif.ppu_addr_valid_in = 1'b1;
    sb_q[0].push_back('{data: e, due: cyc + 3});
  endtask

  task automatic oam_start(input logic [15:0] a, input logic [7:0] e);
    vif.oam_addr_in       = a;
    vif.oam_addr_valid_in = 1'b1;
    sb_q[1].push_back('{data: e, due: cyc + 3});
  endtask

  task automatic cpu_read_start(input logic [15:0] a, input logic [7:0] e);
    vif.cpu_addr_in = a;
    vif.cpu_we_in   = 1'b0;
    vif.cpu_req_in  = 1'b1;
    sb_q[2].push_back('{data: e, due: cyc + 3});
  endtask

  // Run started reads to completion; PPU valids are held through RESP
  task automatic complete();
    tick();
    vif.cpu_req_in = 1'b0;
    vif.cpu_we_in  = 1'b0;
    tick();
    tick();
    tick();
    vif.ppu_addr_valid_in = 1'b0;
    vif.oam_addr_valid_in = 1'b0;
    tick();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    vif.cpu_addr_in  = a;
    vif.cpu_wdata_in = d;
    vif.cpu_we_in    = 1'b1;
    vif.cpu_req_in   = 1'b1;
    tick();
    vif.cpu_req_in   = 1'b0;
    vif.cpu_we_in    = 1'b0;
  endtask

  initial begin
    vif.ppu_addr_in       = 16'h0000;
    vif.ppu_addr_valid_in = 1'b0;
    vif.oam_addr_in       = 16'h0000;
    vif.oam_addr_valid_in = 1'b0;
    vif.mode_in           = 2'd0;
    vif.cpu_addr_in       = 16'h0000;
    vif.cpu_wdata_in      = 8'h00;
    vif.cpu_req_in        = 1'b0;
    vif.cpu_we_in         = 1'b0;

    repeat (3) tick();
    check_val("rst_data",      {24'd0, vif.data_out},           32'h00);
    check_val("rst_oam_data",  {24'd0, vif.oam_data_out},       32'h00);
    check_val("rst_cpu_rdata", {24'd0, vif.cpu_rdata_out},      32'h00);
    check_val("rst_valid",     {31'd0, vif.data_valid_out},     32'd0);
    check_val("rst_oam_valid", {31'd0, vif.oam_data_valid_out}, 32'd0);
    check_val("rst_cpu_valid", {31'd0, vif.cpu_rvalid_out},     32'd0);
    rst_n = 1'b1;
    tick();

    // Basic VRAM path and output hold
    cpu_write(16'h8010, 8'h5A);
    ppu_start(16'h8010, 8'h5A);
    complete();
    tick();
    check_val("ppu_hold_data",  {24'd0, vif.data_out},       32'h5A);
    check_val("ppu_hold_valid", {31'd0, vif.data_valid_out}, 32'd0);

    // Misses on both PPU channels
    ppu_start(16'h7FFF, 8'hFF);
    complete();
    oam_start(16'hFEA0, 8'hFF);
    complete();

    // Simultaneous PPU and OAM fetches
    cpu_write(16'hFE04, 8'h3C);
    ppu_start(16'h8010, 8'h5A);
    oam_start(16'hFE04, 8'h3C);
    complete();

    // CPU reads: VRAM, OAM, unmapped, dropped writes
    cpu_read_start(16'h8010, 8'h5A);
    complete();
    cpu_read_start(16'hFE04, 8'h3C);
    complete();
    cpu_write(16'h1234, 8'hAB);
    cpu_read_start(16'h1234, 8'hFF);
    complete();
    check_val("cpu_hold_data", {24'd0, vif.cpu_rdata_out}, 32'hFF);
    cpu_write(16'hFEA0, 8'h12);
    oam_start(16'hFEA0, 8'hFF);
    complete();

    // Mode 3: CPU locked out of both RAMs when the lock is built in
    vif.mode_in = 2'd3;
    cpu_write(16'h8010, 8'h77);
    ppu_start(16'h8010, LOCK ? 8'h5A : 8'h77);
    complete();
    cpu_read_start(16'h8010, LOCK ? 8'hFF : 8'h77);
    complete();
    cpu_read_start(16'hFE04, LOCK ? 8'hFF : 8'h3C);
    complete();

    // Mode 2: only OAM locked
    vif.mode_in = 2'd2;
    cpu_read_start(16'h8010, LOCK ? 8'h5A : 8'h77);
    complete();
    cpu_read_start(16'hFE04, LOCK ? 8'hFF : 8'h3C);
    complete();
    cpu_write(16'hFE04, 8'h11);
    oam_start(16'hFE04, LOCK ? 8'h3C : 8'h11);
    complete();

    // Mode 0: open again
    vif.mode_in = 2'd0;
    cpu_read_start(16'h8010, LOCK ? 8'h5A : 8'h77);
    complete();
    cpu_write(16'h8010, 8'h5A);
    cpu_write(16'hFE04, 8'h3C);

    // Same-cycle CPU write and PPU accept: PPU sees the old byte
    vif.cpu_addr_in  = 16'h8010;
    vif.cpu_wdata_in = 8'h99;
    vif.cpu_we_in    = 1'b1;
    vif.cpu_req_in   = 1'b1;
    ppu_start(16'h8010, 8'h5A);
    complete();
    ppu_start(16'h8010, 8'h99);
    complete();

    // Write accepted mid-read; a read strobe while busy is ignored
    cpu_read_start(16'h8010, 8'h99);
    tick();
    vif.cpu_addr_in  = 16'h8011;
    vif.cpu_wdata_in = 8'h42;
    vif.cpu_we_in    = 1'b1;
    tick();
    vif.cpu_we_in    = 1'b0;
    tick();
    vif.cpu_req_in   = 1'b0;
    tick();
    tick();
    cpu_read_start(16'h8011, 8'h42);
    complete();

    // Reset one edge after a PPU accept: no pulse, outputs cleared, RAM kept
    ppu_start(16'h8010, 8'h99);
    tick();
    tick();
    rst_n = 1'b0;
    sb_q[0].delete();
    vif.ppu_addr_valid_in = 1'b0;
    #1;
    check_val("rstmid_data",      {24'd0, vif.data_out},       32'h00);
    check_val("rstmid_valid",     {31'd0, vif.data_valid_out}, 32'd0);
    check_val("rstmid_oam_data",  {24'd0, vif.oam_data_out},   32'h00);
    check_val("rstmid_cpu_rdata", {24'd0, vif.cpu_rdata_out},  32'h00);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    ppu_start(16'h8010, 8'h99);
    complete();
    cpu_read_start(16'h8011, 8'h42);
    complete();

    repeat (4) tick();
    check_val("sb_ppu_left", 32'(sb_q[0].size()), 32'd0);
    check_val("sb_oam_left", 32'(sb_q[1].size()), 32'd0);
    check_val("sb_cpu_left", 32'(sb_q[2].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_mem_responder.md
# video_mem_responder

Memory-side responder for the pixel processing unit's fetch interfaces. It owns VRAM ($8000–$9FFF) and OAM ($FE00–$FE9F), answers the PPU's tile/map fetches and OAM scan reads with a fixed-latency valid pulse, and gives the CPU a gated read/write port. It sits between the PPU and the CPU bus in the top level, replacing the constant memory stub.

## Interface
- VRAM_DEPTH, 8192: VRAM bytes; address bits [12:0] of $8000-based offset.
- OAM_DEPTH, 160: OAM bytes.
- clk_in  input  1  100 MHz system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- ppu_addr_in  input  16  PPU fetch address.
- ppu_addr_valid_in  input  1  PPU fetch request (level, held until data_valid_out).
- data_out  output  8  PPU fetch data.
- data_valid_out  output  1  one-cycle pulse, data_out valid.
- oam_addr_in  input  16  PPU OAM scan address.
- oam_addr_valid_in  input  1  OAM request (level, held until oam_data_valid_out).
- oam_data_out  output  8  OAM data.
- oam_data_valid_out  output  1  one-cycle pulse.
- mode_in  input  2  current PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 drawing).
- cpu_addr_in  input  16  CPU address.
- cpu_wdata_in  input  8  CPU write data.
- cpu_req_in  input  1  one-cycle CPU request strobe.
- cpu_we_in  input  1  1 = write, 0 = read; sampled with cpu_req_in.
- cpu_rdata_out  output  8  CPU read data.
- cpu_rvalid_out  output  1  one-cycle pulse for CPU reads.

## Operation
- Three independent channels (PPU-VRAM, PPU-OAM, CPU); each has its own FSM: IDLE → RD1 → RD2 → RESP → IDLE.
- IDLE: request seen (valid high, or cpu_req_in with cpu_we_in=0) → latch address and range-hit flag, drive RAM address, go RD1. RD1 → RD2 unconditionally. RD2: RAM data available, register output → RESP. RESP: valid pulse high one cycle → IDLE.
- PPU channels never gated by mode.
- Range decode: VRAM hit when addr[15:13]==3'b100. OAM hit when addr in $FE00–$FE9F. Miss on any channel returns $FF with identical latency and pulse.
- CPU address selects VRAM, OAM, or miss ($FF on read, write dropped).
- CPU writes: complete in one cycle (no FSM traversal, no rvalid pulse). Accepted on cpu_req_in even while a CPU read is in flight.
- cpu_req_in while the CPU FSM is not IDLE with cpu_we_in=0: ignored (CPU must wait for cpu_rvalid_out).
- RAMs are true dual-port, read-first. Port A serves PPU, port B serves CPU. A same-cycle CPU write and PPU read of the same byte returns the old byte to the PPU.

## Timing
- Request accepted at edge N (IDLE). RAM data is registered at N+2, and the valid pulse is high during cycle N+3.
- Earliest next accept on that channel is edge N+4. A PPU holding valid high through RESP does not cause a double accept.
- data_out, oam_data_out, and cpu_rdata_out hold their last value until the next response.
- Reset (asynchronous assert, synchronous-release usage):
  - All FSMs go to IDLE.
  - All valid outputs are 0.
  - All data outputs are $00.
  - In-flight requests are dropped with no pulse.
  - RAM contents are not cleared.
- Latched address fields are 16 bits. The OAM index is addr[7:0] and is used only on a hit, so no wrap-around occurs.

## Configuration
- VIDEO_MEM_LOCK_EN defined: CPU access is gated by mode_in, sampled at request acceptance.
  - In mode 3, CPU VRAM and OAM reads return $FF and writes are dropped.
  - In mode 2, OAM reads return $FF and OAM writes are dropped; VRAM is open.
- VIDEO_MEM_LOCK_EN undefined: the CPU always has access, and mode_in is unused.

## Structure
- Package video_mem_pkg holds:
  - VRAM_BASE = 16'h8000, OAM_BASE = 16'hFE00, OAM_LAST = 16'hFE9F, OPEN_BUS = 8'hFF.
  - typedef enum ppu_mode_t {HBLANK, VBLANK, OAM_SCAN, DRAWING}.
  - typedef enum resp_state_t {IDLE, RD1, RD2, RESP}.
- Sub-module video_dpram (parameters DEPTH, WIDTH): true dual-port, read-first, 2-cycle registered read latency. It is instantiated once for VRAM and once for OAM.

## Test plan
- CPU write $5A to $8010, then PPU request $8010 at edge N → data_out=$5A, data_valid_out high only in cycle N+3.
- PPU request $7FFF → data_out=$FF, pulse at N+3. OAM request $FEA0 → oam_data_out=$FF, pulse at N+3.
- CPU write $3C to $FE04, then OAM request $FE04 while a PPU request to $8010 is issued in the same cycle → both pulses at N+3 with $3C and $5A.
- With VIDEO_MEM_LOCK_EN and mode_in=3: CPU write $77 to $8010, then CPU read $8010 → cpu_rdata_out=$FF. Then with mode_in=0, CPU read $8010 → $5A.
- Same-cycle CPU write $99 to $8010 and PPU accept of $8010 → PPU gets $5A. The next PPU read gets $99.
- Assert rst_n_in low at N+1 of an in-flight PPU read → no data_valid_out pulse, outputs $00. After release, RAM still returns $99 at $8010.
